// File: rtl/flags_bank_pkg.sv
// -----------------------------------------------------------------------------
// flags_bank_pkg
// Shared definitions for the flags bank:
//   - commit FSM state encoding
//   - default mask of register-0 bits cleared by the capture-finish event
//   - byte-lane merge helper used by every flag register
// -----------------------------------------------------------------------------
package flags_bank_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // Arm/run bit of register 0 (bit 8) self-clears on finish.
   localparam logic [31:0] DEFAULT_FINISH_CLR_MASK = 32'h0000_0100;

   // Returns new_byte when its lane is enabled, otherwise keeps old_byte.
   function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                           input logic [7:0] new_byte,
                                           input logic       en);
      return en ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/flags_bank_if.sv
// -----------------------------------------------------------------------------
// flags_bank_if
// Host-side bundle of the flags bank.
//   write : wr_en, wr_addr, wr_data, wr_be
//   commit: commit_req, busy, finish_now  ->  pending, commit_ack
//   read  : rd_addr, rd_shadow            ->  rd_data (registered)
//   view  : flags_flat (active registers, reg 0 in the LSBs)
// Modports: master = host / capture side, slave = flags_bank.
// -----------------------------------------------------------------------------
interface flags_bank_if #(
   parameter int NUM_REGS   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 2
);

   logic                           wr_en;
   logic [ADDR_WIDTH-1:0]          wr_addr;
   logic [DATA_WIDTH-1:0]          wr_data;
   logic [DATA_WIDTH/8-1:0]        wr_be;
   logic                           commit_req;
   logic                           busy;
   logic                           finish_now;
   logic [ADDR_WIDTH-1:0]          rd_addr;
   logic                           rd_shadow;
   logic [DATA_WIDTH-1:0]          rd_data;
   logic [NUM_REGS*DATA_WIDTH-1:0] flags_flat;
   logic                           pending;
   logic                           commit_ack;

   modport master (
      output wr_en, wr_addr, wr_data, wr_be,
      output commit_req, busy, finish_now,
      output rd_addr, rd_shadow,
      input  rd_data, flags_flat, pending, commit_ack
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be,
      input  commit_req, busy, finish_now,
      input  rd_addr, rd_shadow,
      output rd_data, flags_flat, pending, commit_ack
   );

endinterface

// File: rtl/flags_bank_reg.sv
// -----------------------------------------------------------------------------
// flags_bank_reg
// One DATA_WIDTH flag register.
//   clock, reset_n : clock / asynchronous active-low reset (clears to 0)
//   wr_en, wr_data, wr_be : byte-enabled write
//   load_en, load_data    : whole-word load (commit copy)
//   clr_mask              : bits forced to 0 on this edge
//   q                     : register value
// Precedence on one edge: load, then byte write on top, then clear mask.
// -----------------------------------------------------------------------------
module flags_bank_reg
   import flags_bank_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    load_en,
   input  logic [DATA_WIDTH-1:0]   load_data,
   input  logic [DATA_WIDTH-1:0]   clr_mask,
   output logic [DATA_WIDTH-1:0]   q
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] q_reg;
   logic [DATA_WIDTH-1:0] q_next;
   logic [DATA_WIDTH-1:0] base_val;
   logic [DATA_WIDTH-1:0] merged_val;

   assign base_val = load_en ? load_data : q_reg;

   generate
      for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
         assign merged_val[gi*8 +: 8] = be_merge(base_val[gi*8 +: 8],
                                                 wr_data[gi*8 +: 8],
                                                 wr_en & wr_be[gi]);
      end
   endgenerate

   // Clear mask wins over both load and write for its bits only.
   assign q_next = merged_val & ~clr_mask;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) q_reg <= '0;
      else          q_reg <= q_next;
   end

   assign q = q_reg;

endmodule

// File: rtl/flags_bank.sv
// -----------------------------------------------------------------------------
// flags_bank
// Multi-register flags/configuration bank with shadow/active copies.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : flags_bank_if.slave (host writes, commit handshake, finish
//             event, registered readback, flattened active registers)
// Host writes land in the shadow copy; a commit copies shadow to active,
// deferred while busy is high. finish_now clears FINISH_CLR_MASK bits of
// register 0 in both copies so a later commit cannot re-arm the capture.
// With SHADOW=0 writes hit both copies at once and commit only handshakes.
// -----------------------------------------------------------------------------
module flags_bank
   import flags_bank_pkg::*;
#(
   parameter int                    NUM_REGS        = 4,
   parameter int                    DATA_WIDTH      = 32,
   parameter int                    ADDR_WIDTH      = 2,
   parameter bit                    SHADOW          = 1'b1,
   parameter logic [DATA_WIDTH-1:0] FINISH_CLR_MASK = DATA_WIDTH'(DEFAULT_FINISH_CLR_MASK)
) (
   input  logic         clock,
   input  logic         reset_n,
   flags_bank_if.slave  bus
);

   logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] active_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] clr_vec  [NUM_REGS];
   logic [NUM_REGS-1:0]   wr_hit;

   state_t                state_reg;
   state_t                state_next;
   logic                  req_hold_reg;
   logic                  req_hold_next;
   logic                  ack_reg;
   logic                  commit_fire;
   logic [DATA_WIDTH-1:0] rd_data_reg;
   logic [DATA_WIDTH-1:0] rd_next;

   // ---------------------------------------------------------------- registers
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         // Out-of-range addresses match no register and are dropped here.
         assign wr_hit[gi] = bus.wr_en && (bus.wr_addr == ADDR_WIDTH'(gi));

         if (gi == 0) begin : g_clr0
            assign clr_vec[gi] = bus.finish_now ? FINISH_CLR_MASK : '0;
         end else begin : g_clrn
            assign clr_vec[gi] = '0;
         end

         flags_bank_reg #(.DATA_WIDTH(DATA_WIDTH)) u_shadow (
            .clock     (clock),
            .reset_n   (reset_n),
            .wr_en     (wr_hit[gi]),
            .wr_data   (bus.wr_data),
            .wr_be     (bus.wr_be),
            .load_en   (1'b0),
            .load_data ('0),
            .clr_mask  (clr_vec[gi]),
            .q         (shadow_q[gi])
         );

         if (SHADOW) begin : g_buffered
            // Active only changes on the COMMIT exit edge, from the
            // shadow value held during the COMMIT cycle.
            flags_bank_reg #(.DATA_WIDTH(DATA_WIDTH)) u_active (
               .clock     (clock),
               .reset_n   (reset_n),
               .wr_en     (1'b0),
               .wr_data   (bus.wr_data),
               .wr_be     (bus.wr_be),
               .load_en   (commit_fire),
               .load_data (shadow_q[gi]),
               .clr_mask  (clr_vec[gi]),
               .q         (active_q[gi])
            );
         end else begin : g_direct
            // Both copies see identical writes and clears, so they never
            // diverge and the commit copy can be skipped.
            flags_bank_reg #(.DATA_WIDTH(DATA_WIDTH)) u_active (
               .clock     (clock),
               .reset_n   (reset_n),
               .wr_en     (wr_hit[gi]),
               .wr_data   (bus.wr_data),
               .wr_be     (bus.wr_be),
               .load_en   (1'b0),
               .load_data ('0),
               .clr_mask  (clr_vec[gi]),
               .q         (active_q[gi])
            );
         end

         assign bus.flags_flat[gi*DATA_WIDTH +: DATA_WIDTH] = active_q[gi];
      end
   endgenerate

   // --------------------------------------------------------------- commit FSM
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         req_hold_reg <= 1'b0;
         ack_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         req_hold_reg <= req_hold_next;
         ack_reg      <= commit_fire;
      end
   end

   always_comb begin
      state_next    = state_reg;
      req_hold_next = req_hold_reg;
      unique case (state_reg)
         IDLE: begin
            if (bus.commit_req || req_hold_reg) begin
               req_hold_next = 1'b0;
               state_next    = bus.busy ? WAIT : COMMIT;
            end
         end
         WAIT: begin
            // Extra requests here are absorbed into the pending commit.
            if (!bus.busy) state_next = COMMIT;
         end
         COMMIT: begin
            state_next = IDLE;
            // A request during the copy cycle is remembered and served
            // from IDLE as a fresh commit.
            if (bus.commit_req) req_hold_next = 1'b1;
         end
         default: begin
            state_next    = IDLE;
            req_hold_next = 1'b0;
         end
      endcase
   end

   assign commit_fire    = (state_reg == COMMIT);
   assign bus.pending    = (state_reg == WAIT);
   assign bus.commit_ack = ack_reg;

   // ----------------------------------------------------------------- readback
   always_comb begin
      rd_next = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (bus.rd_addr == ADDR_WIDTH'(i))
            rd_next = bus.rd_shadow ? shadow_q[i] : active_q[i];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rd_data_reg <= '0;
      else          rd_data_reg <= rd_next;
   end

   assign bus.rd_data = rd_data_reg;

endmodule

// File: tb/tb_flags_bank.sv
// -----------------------------------------------------------------------------
// tb_flags_bank
// Directed bench for flags_bank. dut_a: NUM_REGS=3, SHADOW=1 (address 3 is
// out of range). dut_b: NUM_REGS=4, SHADOW=0. Expected values are pushed to
// a scoreboard queue as stimulus is driven and popped when the DUT output is
// sampled, 1 time unit after the active edge.
// -----------------------------------------------------------------------------
module tb_flags_bank;

   logic clock = 1'b0;
   logic reset_n;

   always #5 clock = ~clock;

   flags_bank_if #(.NUM_REGS(3), .DATA_WIDTH(32), .ADDR_WIDTH(2)) bus_a ();
   flags_bank_if #(.NUM_REGS(4), .DATA_WIDTH(32), .ADDR_WIDTH(2)) bus_b ();

   flags_bank #(
      .NUM_REGS(3), .DATA_WIDTH(32), .ADDR_WIDTH(2), .SHADOW(1'b1),
      .FINISH_CLR_MASK(32'h0000_0100)
   ) dut_a (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_a)
   );

   flags_bank #(
      .NUM_REGS(4), .DATA_WIDTH(32), .ADDR_WIDTH(2), .SHADOW(1'b0),
      .FINISH_CLR_MASK(32'h0000_0100)
   ) dut_b (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_b)
   );

   int           n_total = 0;
   int           n_bad   = 0;
   string        tag_q[$];
   logic [127:0] exp_q[$];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input string tag, input logic [127:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic pop_check(input logic [127:0] obs);
      string        tag;
      logic [127:0] expv;
      n_total++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $error("FAIL scoreboard_underflow observed=%0h required=none", obs);
      end else begin
         tag  = tag_q.pop_front();
         expv = exp_q.pop_front();
         assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, expv);
         end
      end
   endtask

   function automatic logic [127:0] flat3(input logic [31:0] r2,
                                          input logic [31:0] r1,
                                          input logic [31:0] r0);
      return {32'h0, r2, r1, r0};
   endfunction

   task automatic write_a(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
      bus_a.wr_en   = 1'b1;
      bus_a.wr_addr = a;
      bus_a.wr_data = d;
      bus_a.wr_be   = be;
      tick();
      bus_a.wr_en   = 1'b0;
      $display("write a addr=%0d data=%h be=%b", a, d, be);
   endtask

   task automatic read_a(input string tag, input logic [1:0] a, input logic sh,
                         input logic [31:0] expv);
      bus_a.rd_addr   = a;
      bus_a.rd_shadow = sh;
      push(tag, 128'(expv));
      tick();
      pop_check(128'(bus_a.rd_data));
      $display("read a addr=%0d shadow=%0d data=%h", a, sh, bus_a.rd_data);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      {bus_a.wr_en, bus_a.wr_addr, bus_a.wr_data, bus_a.wr_be} = '0;
      {bus_a.commit_req, bus_a.busy, bus_a.finish_now, bus_a.rd_addr, bus_a.rd_shadow} = '0;
      {bus_b.wr_en, bus_b.wr_addr, bus_b.wr_data, bus_b.wr_be} = '0;
      {bus_b.commit_req, bus_b.busy, bus_b.finish_now, bus_b.rd_addr, bus_b.rd_shadow} = '0;

      // ---- reset state
      #2;
      push("rst_flat_a", '0);     pop_check(128'(bus_a.flags_flat));
      push("rst_rd_a", '0);       pop_check(128'(bus_a.rd_data));
      push("rst_pending_a", '0);  pop_check(128'(bus_a.pending));
      push("rst_ack_a", '0);      pop_check(128'(bus_a.commit_ack));
      push("rst_flat_b", '0);     pop_check(bus_b.flags_flat);
      $display("reset state checked");
      #5;
      reset_n = 1'b1;
      tick();

      // ---- masked write then commit with busy=0
      write_a(2'd1, 32'h1234_5678, 4'b0101);
      push("mw_flat_pre", flat3(0, 0, 0)); pop_check(128'(bus_a.flags_flat));
      read_a("mw_rd_shadow1", 2'd1, 1'b1, 32'h0034_0078);
      bus_a.commit_req = 1'b1;
      push("c_flat_N", flat3(0, 0, 0));
      push("c_ack_N", '0);
      tick();
      bus_a.commit_req = 1'b0;
      pop_check(128'(bus_a.flags_flat));
      pop_check(128'(bus_a.commit_ack));
      push("c_flat_N1", flat3(0, 32'h0034_0078, 0));
      push("c_ack_N1", 128'd1);
      tick();
      pop_check(128'(bus_a.flags_flat));
      pop_check(128'(bus_a.commit_ack));
      push("c_ack_N2", '0);
      tick();
      pop_check(128'(bus_a.commit_ack));
      $display("commit a ack pulse done");
      read_a("c_rd_active1", 2'd1, 1'b0, 32'h0034_0078);

      // ---- deferred commit
      write_a(2'd1, 32'hAAAA_5555, 4'b1111);
      bus_a.busy = 1'b1;
      bus_a.commit_req = 1'b1;
      push("d_pending1", 128'd1);
      push("d_flat1", flat3(0, 32'h0034_0078, 0));
      tick();
      bus_a.commit_req = 1'b0;
      pop_check(128'(bus_a.pending));
      pop_check(128'(bus_a.flags_flat));
      tick();
      bus_a.commit_req = 1'b1;
      push("d_pending2", 128'd1);
      push("d_ack2", '0);
      push("d_flat2", flat3(0, 32'h0034_0078, 0));
      tick();
      bus_a.commit_req = 1'b0;
      pop_check(128'(bus_a.pending));
      pop_check(128'(bus_a.commit_ack));
      pop_check(128'(bus_a.flags_flat));
      bus_a.busy = 1'b0;
      push("d_pending_commit", '0);
      push("d_ack_commit", '0);
      push("d_flat_commit", flat3(0, 32'h0034_0078, 0));
      tick();
      pop_check(128'(bus_a.pending));
      pop_check(128'(bus_a.commit_ack));
      pop_check(128'(bus_a.flags_flat));
      push("d_flat_done", flat3(0, 32'hAAAA_5555, 0));
      push("d_ack_done", 128'd1);
      tick();
      pop_check(128'(bus_a.flags_flat));
      pop_check(128'(bus_a.commit_ack));
      push("d_ack_after1", '0);
      tick();
      pop_check(128'(bus_a.commit_ack));
      push("d_ack_after2", '0);
      tick();
      pop_check(128'(bus_a.commit_ack));
      $display("deferred commit a done");

      // ---- finish clear
      write_a(2'd0, 32'h0000_01FF, 4'b1111);
      bus_a.commit_req = 1'b1;
      tick();
      bus_a.commit_req = 1'b0;
      tick();
      push("f_flat_armed", flat3(0, 32'hAAAA_5555, 32'h0000_01FF));
      pop_check(128'(bus_a.flags_flat));
      bus_a.finish_now = 1'b1;
      push("f_flat_cleared", flat3(0, 32'hAAAA_5555, 32'h0000_00FF));
      tick();
      bus_a.finish_now = 1'b0;
      pop_check(128'(bus_a.flags_flat));
      read_a("f_rd_shadow0", 2'd0, 1'b1, 32'h0000_00FF);
      bus_a.commit_req = 1'b1;
      tick();
      bus_a.commit_req = 1'b0;
      push("f_flat_recommit", flat3(0, 32'hAAAA_5555, 32'h0000_00FF));
      tick();
      pop_check(128'(bus_a.flags_flat));
      $display("finish clear a done");

      // ---- commit copy and finish on the same edge
      write_a(2'd0, 32'h0000_0101, 4'b1111);
      bus_a.commit_req = 1'b1;
      tick();
      bus_a.commit_req = 1'b0;
      bus_a.finish_now = 1'b1;
      push("s_flat", flat3(0, 32'hAAAA_5555, 32'h0000_0001));
      push("s_ack", 128'd1);
      tick();
      bus_a.finish_now = 1'b0;
      pop_check(128'(bus_a.flags_flat));
      pop_check(128'(bus_a.commit_ack));
      read_a("s_rd_shadow0", 2'd0, 1'b1, 32'h0000_0001);

      // ---- host write to reg 0 and finish on the same edge
      bus_a.finish_now = 1'b1;
      write_a(2'd0, 32'hFFFF_FFFF, 4'b1111);
      bus_a.finish_now = 1'b0;
      push("fw_flat", flat3(0, 32'hAAAA_5555, 32'h0000_0001));
      pop_check(128'(bus_a.flags_flat));
      read_a("fw_rd_shadow0", 2'd0, 1'b1, 32'hFFFF_FEFF);

      // ---- out-of-range write / read, shadow readback before commit
      write_a(2'd3, 32'hFFFF_FFFF, 4'b1111);
      push("oor_flat", flat3(0, 32'hAAAA_5555, 32'h0000_0001));
      pop_check(128'(bus_a.flags_flat));
      read_a("oor_rd_shadow2", 2'd2, 1'b1, 32'h0000_0000);
      read_a("oor_rd_shadow1", 2'd1, 1'b1, 32'hAAAA_5555);
      read_a("oor_rd_addr3_sh", 2'd3, 1'b1, 32'h0000_0000);
      read_a("oor_rd_addr3_act", 2'd3, 1'b0, 32'h0000_0000);
      write_a(2'd1, 32'hCAFE_F00D, 4'b1111);
      read_a("pre_rd_shadow1", 2'd1, 1'b1, 32'hCAFE_F00D);
      read_a("pre_rd_active1", 2'd1, 1'b0, 32'hAAAA_5555);

      // ---- SHADOW=0 instance
      bus_b.wr_en   = 1'b1;
      bus_b.wr_addr = 2'd2;
      bus_b.wr_data = 32'h1111_2222;
      bus_b.wr_be   = 4'b1100;
      push("b_flat_write", {32'h0, 32'h1111_0000, 32'h0, 32'h0});
      tick();
      bus_b.wr_en = 1'b0;
      pop_check(bus_b.flags_flat);
      $display("write b addr=2 flat=%h", bus_b.flags_flat);
      bus_b.commit_req = 1'b1;
      push("b_ack_N", '0);
      tick();
      bus_b.commit_req = 1'b0;
      pop_check(128'(bus_b.commit_ack));
      push("b_ack_N1", 128'd1);
      push("b_flat_N1", {32'h0, 32'h1111_0000, 32'h0, 32'h0});
      tick();
      pop_check(128'(bus_b.commit_ack));
      pop_check(bus_b.flags_flat);
      push("b_ack_N2", '0);
      tick();
      pop_check(128'(bus_b.commit_ack));
      $display("commit b ack pulse done");

      // ---- asynchronous reset mid-WAIT with active[1]=DEADBEEF
      write_a(2'd1, 32'hDEAD_BEEF, 4'b1111);
      bus_a.commit_req = 1'b1;
      tick();
      bus_a.commit_req = 1'b0;
      tick();
      push("r_flat_live", flat3(0, 32'hDEAD_BEEF, 32'hFFFF_FEFF));
      pop_check(128'(bus_a.flags_flat));
      read_a("r_rd_live", 2'd1, 1'b0, 32'hDEAD_BEEF);
      bus_a.busy = 1'b1;
      bus_a.commit_req = 1'b1;
      push("r_pending_live", 128'd1);
      tick();
      bus_a.commit_req = 1'b0;
      pop_check(128'(bus_a.pending));
      #3;
      reset_n = 1'b0;
      push("r_flat_async", '0);
      push("r_rd_async", '0);
      push("r_pending_async", '0);
      #1;
      pop_check(128'(bus_a.flags_flat));
      pop_check(128'(bus_a.rd_data));
      pop_check(128'(bus_a.pending));
      $display("async reset a checked");
      bus_a.busy = 1'b0;
      #2;
      reset_n = 1'b1;
      push("r_ack_after1", '0);
      push("r_flat_after1", '0);
      tick();
      pop_check(128'(bus_a.commit_ack));
      pop_check(128'(bus_a.flags_flat));
      push("r_ack_after2", '0);
      tick();
      pop_check(128'(bus_a.commit_ack));

      // ---- every pushed expectation must have been consumed
      n_total++;
      assert (exp_q.size() == 0) else begin
         n_bad++;
         $error("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
